alu_rsp_collector: RTL and testbench
====================================

Name: alu_rsp_collector

Overview:
- Response-side counterpart of the ALU stimulus path: watches the ALU BFM's start/done/result signals and captures each 16-bit result in issue order into a batch buffer.
- Returns a full batch of NUM results to the host side via a valid/ready handshake.
- Throttles the upstream driver through an issue-ready signal so results are never lost.
- Flags protocol errors: overflow, spurious done, and timeout.

Parameters:
- NUM, 100, results per batch (matches the stimulus batch size).
- RES_WIDTH, 16, width of one ALU result.
- TIMEOUT, 64, max cycles with outstanding ops and no done before timeout_o sets.
- CNT_W, $clog2(NUM+1), width of count fields.

Ports:
- clk_i  in  1  single clock, all logic on posedge.
- reset_i  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle strobe: an op was issued to the ALU.
- done_i  in  1  one-cycle strobe: ALU result valid on res_i.
- res_i  in  RES_WIDTH  ALU result, sampled when done_i=1.
- flush_i  in  1  force out a partial batch.
- issue_ready_o  out  1  upstream may issue (drives the driver's tready).
- batch_valid_o  out  1  batch available.
- batch_ready_i  in  1  host accepts batch.
- batch_data_o  out  NUM*RES_WIDTH  result k at [k*RES_WIDTH +: RES_WIDTH].
- batch_count_o  out  CNT_W  number of valid results in the batch.
- overflow_o  out  1  sticky error flag.
- spurious_o  out  1  sticky error flag.
- timeout_o  out  1  sticky error flag.

Behaviour:
- Reset values (reset_i=1 at posedge):
  - State goes to COLLECT.
  - count, outstanding, timer and all flags go to 0.
  - batch_valid_o=0 and batch_count_o=0.
  - batch_data_o contents are don't-care.
  - Reset mid-batch discards everything captured.
- States: COLLECT (capturing) and DRAIN (batch_valid_o=1, capture blocked).
- outstanding counter:
  - +1 on start_i, −1 on an accepted or discarded done_i.
  - Both in the same cycle: net 0.
  - Range 0..NUM.
- Capture in COLLECT, when done_i=1 and (outstanding>0 or start_i=1):
  - slot[count] <= res_i and count++.
  - Result is visible on batch_data_o from the next cycle.
  - Order equals done order.
- COLLECT→DRAIN:
  - When a capture makes count==NUM, batch_valid_o=1 in the cycle after that capture edge.
  - Or when flush_i=1 with count>0, or with a capture in the same cycle. The capture is applied first, then DRAIN is entered.
  - flush_i with count==0 and no capture is ignored.
- DRAIN→COLLECT:
  - On batch_valid_o && batch_ready_i.
  - count clears the same edge.
  - Slots are not cleared; host reads only [0, batch_count_o).
- batch_count_o equals count, held stable through DRAIN.
- batch_data_o is stable while batch_valid_o=1.
- issue_ready_o = (state==COLLECT) && (count+outstanding < NUM). Combinational from registers.
- Errors (all sticky until reset):
  - done_i with outstanding==0 and start_i=0: spurious_o<=1, result discarded, outstanding unchanged.
  - done_i while in DRAIN: overflow_o<=1, result discarded, outstanding decremented.
  - start_i while issue_ready_o==0: overflow_o<=1. Outstanding is still incremented, saturating at NUM.
- Timeout timer:
  - Clears when outstanding==0 or done_i=1; otherwise increments, saturating.
  - When timer reaches TIMEOUT, timeout_o<=1.
  - No other effect: capture continues.
- Simultaneous start_i and done_i are both processed in one cycle, with no error when outstanding was 0 (back-to-back single-cycle op).

Test Plan (NUM=4, TIMEOUT=8):
- Normal batch: 4 start/done pairs with results 0x0003, 0x00FF, 0x1234, 0xFFFF → batch_valid_o=1 the cycle after the 4th done; batch_count_o=4; slots 0..3 hold those results in order. With batch_ready_i=1, batch_valid_o drops next cycle and issue_ready_o returns to 1.
- Backpressure: full batch held with batch_ready_i=0 for 10 cycles → issue_ready_o=0, batch_data_o and batch_count_o stable; a forced done_i → overflow_o=1 and batch data unchanged.
- Flush: 2 results captured (0x0011, 0x0022), then flush_i=1 → DRAIN with batch_count_o=2. flush_i with count=0 produces no batch_valid_o.
- Spurious/same-cycle: done_i with no outstanding → spurious_o=1, count stays 0. start_i and done_i in the same cycle with res_i=0x0042 → captured in slot 0, no error.
- Timeout: 1 start_i and no done for 8 cycles → timeout_o=1. A later done_i (0x0007) is still captured, with count=1.
- Reset mid-batch: reset_i=1 for 1 cycle after 3 captures → count=0, all flags 0, issue_ready_o=1; next 4 results form a clean batch.

Source files
------------

// File: rtl/alu_rsp_collector.sv
// rtl/alu_rsp_collector.sv - collects ALU results in done order into NUM-deep batches
// Handshakes batches out, throttles issue, and flags overflow/spurious/timeout.
module alu_rsp_collector #(
  parameter int NUM       = 100,
  parameter int RES_WIDTH = 16,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = $clog2(NUM+1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     done_i,
  input  logic [RES_WIDTH-1:0]     res_i,
  input  logic                     flush_i,
  output logic                     issue_ready_o,
  output logic                     batch_valid_o,
  input  logic                     batch_ready_i,
  output logic [NUM*RES_WIDTH-1:0] batch_data_o,
  output logic [CNT_W-1:0]         batch_count_o,
  output logic                     overflow_o,
  output logic                     spurious_o,
  output logic                     timeout_o
);

  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic {COLLECT, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CNT_W-1:0]         out_q, out_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic                     ovf_q, ovf_d, spur_q, spur_d, to_q, to_d;
  logic [NUM*RES_WIDTH-1:0] data_q;
  logic                     spur_ev, real_done, capture;
  logic [CNT_W:0]           pending;

  assign pending       = {1'b0, count_q} + {1'b0, out_q};
  assign issue_ready_o = (state_q == COLLECT) && (pending < (CNT_W+1)'(NUM));
  // A same-cycle start makes a done legal even with nothing outstanding.
  assign spur_ev       = done_i && (out_q == '0) && !start_i;
  assign real_done     = done_i && !spur_ev;
  assign capture       = real_done && (state_q == COLLECT);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d   = out_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    spur_d  = spur_q;
    to_d    = to_q;

    if (capture) count_d = count_q + 1'b1;

    case (state_q)
      COLLECT: begin
        if ((capture && (count_q == CNT_W'(NUM-1))) ||
            (flush_i && ((count_q != '0) || capture)))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (batch_ready_i) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (start_i && !real_done) begin
      if (out_q != CNT_W'(NUM)) out_d = out_q + 1'b1;
    end else if (!start_i && real_done) begin
      out_d = out_q - 1'b1;
    end

    if ((out_q == '0) || done_i)
      timer_d = '0;
    else if (timer_q != TW'(TIMEOUT))
      timer_d = timer_q + 1'b1;
    if (timer_d == TW'(TIMEOUT)) to_d = 1'b1;

    if (spur_ev) spur_d = 1'b1;
    if ((start_i && !issue_ready_o) || (done_i && (state_q == DRAIN))) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= COLLECT;
      count_q <= '0;
      out_q   <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      spur_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      spur_q  <= spur_d;
      to_q    <= to_d;
    end
  end

  // Slot storage carries no reset; only [0, count) is ever meaningful.
  for (genvar k = 0; k < NUM; k++) begin : g_slot
    always_ff @(posedge clk_i) begin
      if (!reset_i && capture && (count_q == CNT_W'(k)))
        data_q[k*RES_WIDTH +: RES_WIDTH] <= res_i;
    end
  end

  assign batch_valid_o = (state_q == DRAIN);
  assign batch_count_o = count_q;
  assign batch_data_o  = data_q;
  assign overflow_o    = ovf_q;
  assign spurious_o    = spur_q;
  assign timeout_o     = to_q;

endmodule

// File: tb/tb_alu_rsp_collector.sv
// tb/tb_alu_rsp_collector.sv - directed plus randomized bench for alu_rsp_collector
// A queue-based reference model is compared against the DUT every cycle.
module tb_alu_rsp_collector;
  localparam int NUM = 4;
  localparam int RW = 16;
  localparam int TIMEOUT = 8;
  localparam int CNT_W = $clog2(NUM+1);

  logic clk = 0;
  logic rst = 1, start = 0, done = 0, flush = 0, rdy = 0;
  logic [RW-1:0] res = '0;
  logic issue_ready, bvalid, ovf, spur, tout;
  logic [NUM*RW-1:0] bdata;
  logic [CNT_W-1:0] bcount;

  int checks = 0;
  int errors = 0;

  alu_rsp_collector #(.NUM(NUM), .RES_WIDTH(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .done_i(done), .res_i(res),
    .flush_i(flush), .issue_ready_o(issue_ready), .batch_valid_o(bvalid),
    .batch_ready_i(rdy), .batch_data_o(bdata), .batch_count_o(bcount),
    .overflow_o(ovf), .spurious_o(spur), .timeout_o(tout)
  );

  always #5 clk = ~clk;

  // Reference model: batch contents as a queue, outstanding ops as an integer.
  logic [RW-1:0] m_items[$];
  bit m_valid, m_ovf, m_spur, m_to, started;
  int m_out, m_t;

  function automatic bit m_ir();
    return !m_valid && (m_items.size() + m_out < NUM);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit sp, rd, ir;
    int n;
    if (rst) begin
      m_items.delete();
      m_valid = 0; m_out = 0; m_t = 0;
      m_ovf = 0; m_spur = 0; m_to = 0;
      started = 1;
    end else begin
      sp = done && m_out == 0 && !start;
      rd = done && !sp;
      ir = m_ir();
      if (start && !ir) m_ovf = 1;
      if (done && m_valid) m_ovf = 1;
      if (sp) m_spur = 1;
      if (m_out == 0 || done) m_t = 0;
      else if (m_t < TIMEOUT) m_t++;
      if (m_t == TIMEOUT) m_to = 1;
      n = m_out + (start ? 1 : 0) - (rd ? 1 : 0);
      m_out = (n > NUM) ? NUM : n;
      if (!m_valid) begin
        if (rd) m_items.push_back(res);
        if (m_items.size() == NUM) m_valid = 1;
        else if (flush && m_items.size() > 0) m_valid = 1;
      end else if (rdy) begin
        m_valid = 0;
        m_items.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("batch_valid", 32'(bvalid), 32'(m_valid));
      chk("batch_count", 32'(bcount), 32'(m_items.size()));
      chk("issue_ready", 32'(issue_ready), 32'(m_ir()));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("spurious", 32'(spur), 32'(m_spur));
      chk("timeout", 32'(tout), 32'(m_to));
      for (int k = 0; k < m_items.size(); k++)
        chk($sformatf("slot%0d", k), 32'(bdata[k*RW +: RW]), 32'(m_items[k]));
    end
  end

  task automatic step(input bit st, input bit dn, input logic [RW-1:0] r,
                      input bit fl, input bit rd, input bit rs);
    start = st; done = dn; res = r; flush = fl; rdy = rd; rst = rs;
    @(posedge clk);
    #1;
    start = 0; done = 0; flush = 0; rdy = 0; rst = 0;
  endtask

  task automatic pair(input logic [RW-1:0] r);
    step(1, 0, '0, 0, 0, 0);
    step(0, 1, r, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0, 0, 1);
  endtask

  logic [RW-1:0] vals[4];
  logic [NUM*RW-1:0] snap;

  initial begin
    do_reset();
    chk("rst_valid", 32'(bvalid), 0);
    chk("rst_count", 32'(bcount), 0);
    chk("rst_issue_ready", 32'(issue_ready), 1);

    // Normal batch
    vals[0] = 16'h0003; vals[1] = 16'h00FF; vals[2] = 16'h1234; vals[3] = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      chk("pre_full_valid", 32'(bvalid), 0);
      pair(vals[i]);
    end
    chk("full_valid", 32'(bvalid), 1);
    chk("full_count", 32'(bcount), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_slot%0d", i), 32'(bdata[i*RW +: RW]), 32'(vals[i]));
      chk($sformatf("model_slot%0d", i), 32'(m_items[i]), 32'(vals[i]));
    end
    step(0, 0, '0, 0, 1, 0);
    chk("accept_valid", 32'(bvalid), 0);
    chk("accept_issue_ready", 32'(issue_ready), 1);

    // Backpressure
    for (int i = 0; i < 4; i++) pair(16'h0100 + 16'(i));
    snap = bdata;
    for (int i = 0; i < 10; i++) step(0, 0, '0, 0, 0, 0);
    chk("bp_issue_ready", 32'(issue_ready), 0);
    chk("bp_count", 32'(bcount), 4);
    chk("bp_data_stable", 32'(bdata == snap), 1);
    chk("bp_ovf_before", 32'(ovf), 0);
    step(0, 1, 16'hDEAD, 0, 0, 0);
    chk("bp_ovf_after", 32'(ovf), 1);
    chk("bp_data_after", 32'(bdata == snap), 1);
    step(0, 0, '0, 0, 1, 0);

    // Flush
    do_reset();
    pair(16'h0011);
    pair(16'h0022);
    chk("pre_flush_valid", 32'(bvalid), 0);
    step(0, 0, '0, 1, 0, 0);
    chk("flush_valid", 32'(bvalid), 1);
    chk("flush_count", 32'(bcount), 2);
    chk("flush_slot1", 32'(bdata[RW +: RW]), 32'h0022);
    step(0, 0, '0, 0, 1, 0);
    step(0, 0, '0, 1, 0, 0);
    chk("empty_flush_valid", 32'(bvalid), 0);

    // Spurious and same-cycle start/done
    do_reset();
    step(0, 1, 16'h0BAD, 0, 0, 0);
    chk("spur_flag", 32'(spur), 1);
    chk("spur_count", 32'(bcount), 0);
    do_reset();
    step(1, 1, 16'h0042, 0, 0, 0);
    chk("same_count", 32'(bcount), 1);
    chk("same_slot0", 32'(bdata[0 +: RW]), 32'h0042);
    chk("same_spur", 32'(spur), 0);
    chk("same_ovf", 32'(ovf), 0);

    // Timeout
    do_reset();
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, '0, 0, 0, 0);
    chk("timeout_early", 32'(tout), 0);
    step(0, 0, '0, 0, 0, 0);
    chk("timeout_set", 32'(tout), 1);
    step(0, 1, 16'h0007, 0, 0, 0);
    chk("timeout_count", 32'(bcount), 1);
    chk("timeout_slot0", 32'(bdata[0 +: RW]), 32'h0007);

    // Reset mid-batch
    do_reset();
    for (int i = 0; i < 3; i++) pair(16'h0A00 + 16'(i));
    step(1, 1, 16'h0001, 0, 0, 1);
    chk("mid_rst_count", 32'(bcount), 0);
    chk("mid_rst_flags", 32'({ovf, spur, tout}), 0);
    chk("mid_rst_issue_ready", 32'(issue_ready), 1);
    for (int i = 0; i < 4; i++) pair(16'h0B00 + 16'(i));
    chk("mid_rst_valid", 32'(bvalid), 1);
    chk("mid_rst_slot0", 32'(bdata[0 +: RW]), 32'h0B00);
    chk("mid_rst_slot3", 32'(bdata[3*RW +: RW]), 32'h0B03);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit st, dn, fl, rd, rs;
      if ($urandom_range(0, 99) < 2) begin
        for (int j = 0; j < TIMEOUT + 3; j++) step(0, 0, '0, 0, 0, 0);
      end
      st = m_ir() ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
      dn = (m_out > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 4);
      fl = $urandom_range(0, 99) < 5;
      rd = $urandom_range(0, 99) < 35;
      rs = $urandom_range(0, 999) < 5;
      step(st, dn, RW'($urandom), fl, rd, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
